// File: rtl/oserdes_word_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : oserdes_word_feeder_if
//  Description : Byte-stream handshake, control and serializer-side signals
//                shared between the word feeder and whatever drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface oserdes_word_feeder_if #(
    parameter int WIDTH      = 4,
    parameter int IN_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 en;
    logic                 pll_lock;
    logic                 train;
    logic [IN_WIDTH-1:0]  din;
    logic                 din_valid;
    logic                 din_ready;
    logic [WIDTH-1:0]     d;
    logic                 load_word;
    logic                 underflow;
    logic [c_LEVEL_W-1:0] level;

    modport master (
        output en, pll_lock, train, din, din_valid,
        input  din_ready, d, load_word, underflow, level
    );

    modport slave (
        input  en, pll_lock, train, din, din_valid,
        output din_ready, d, load_word, underflow, level
    );
endinterface
`default_nettype wire

// File: rtl/oserdes_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : oserdes_word_feeder
//  Description : Buffers a byte stream, slices each byte LSB-first into
//                serializer words and strobes them out at a fixed cadence,
//                with PLL-lock gating, a training pattern and idle fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module oserdes_word_feeder #(
    parameter int               WIDTH         = 4,
    parameter int               IN_WIDTH      = 8,
    parameter int               FIFO_DEPTH    = 4,
    parameter int               LOAD_INTERVAL = 1,
    parameter int               MIN_TRAIN     = 8,
    parameter logic [WIDTH-1:0] TRAIN_WORD    = WIDTH'(4'b0101),
    parameter logic [WIDTH-1:0] IDLE_WORD     = WIDTH'(4'b0000)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    oserdes_word_feeder_if.slave   bus
);
    localparam int c_RATIO = IN_WIDTH / WIDTH;
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_LW    = c_AW + 1;
    localparam int c_SW    = $clog2(c_RATIO) + 1;
    localparam int c_CW    = $clog2(MIN_TRAIN + 1);
    localparam int c_TW    = 5;
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(LOAD_INTERVAL - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_TRAIN     = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_lock_meta;
    logic                  r_lock_sync;
    logic [c_TW-1:0]       r_timer;
    logic [c_CW-1:0]       r_train_cnt;
    logic [IN_WIDTH-1:0]   r_cur;
    logic [c_SW-1:0]       r_slices;
    logic [WIDTH-1:0]      r_d;
    logic                  r_load_word;
    logic                  r_underflow;
    logic [IN_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wp;
    logic [c_AW-1:0]       r_rp;
    logic [c_LW-1:0]       r_level;

    logic w_stop;
    logic w_load;
    logic w_full;
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_run_load;
    logic w_run_to_train;
    logic w_train_to_run;
    logic w_enter_train;
    logic w_flush;

    // Loss of lock or enable overrides everything, including a load due this cycle
    assign w_stop         = !r_lock_sync || !bus.en;
    assign w_load         = (r_state != S_WAIT_LOCK) && !w_stop && (r_timer == c_T_LAST);
    assign w_full         = (r_level == c_LW'(FIFO_DEPTH));
    assign w_empty        = (r_level == '0);
    assign w_ready        = (r_state == S_RUN) && !w_full;
    assign w_push         = bus.din_valid && w_ready;
    assign w_run_load     = w_load && (r_state == S_RUN);
    assign w_pop          = w_run_load && (r_slices == '0) && !w_empty;
    assign w_run_to_train = w_run_load && bus.train;
    assign w_train_to_run = w_load && (r_state == S_TRAIN) && !bus.train
                            && (r_train_cnt >= c_CW'(MIN_TRAIN));
    assign w_enter_train  = ((r_state == S_WAIT_LOCK) && !w_stop) || w_run_to_train;
    assign w_flush        = w_stop || w_enter_train;

    assign bus.din_ready  = w_ready;
    assign bus.d          = r_d;
    assign bus.load_word  = r_load_word;
    assign bus.underflow  = r_underflow;
    assign bus.level      = r_level;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_sync <= r_lock_meta;
        end
    end

    // FIFO storage carries data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= bus.din;
        end
    end

    // State machine, word timer, word slicer and FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_WAIT_LOCK;
            r_timer     <= '0;
            r_train_cnt <= '0;
            r_cur       <= '0;
            r_slices    <= '0;
            r_d         <= '0;
            r_load_word <= 1'b0;
            r_underflow <= 1'b0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
        end else begin
            r_load_word <= w_load;

            if (w_stop) begin
                r_state <= S_WAIT_LOCK;
            end else begin
                case (r_state)
                    S_WAIT_LOCK: r_state <= S_TRAIN;
                    S_TRAIN:     if (w_train_to_run) r_state <= S_RUN;
                    S_RUN:       if (w_run_to_train) r_state <= S_TRAIN;
                    default:     r_state <= S_WAIT_LOCK;
                endcase
            end

            if (w_stop || (r_state == S_WAIT_LOCK) || (r_timer == c_T_LAST)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TW'(1);
            end

            if (w_load) begin
                if (r_state == S_TRAIN) begin
                    r_d <= TRAIN_WORD;
                    if (r_train_cnt < c_CW'(MIN_TRAIN)) begin
                        r_train_cnt <= r_train_cnt + c_CW'(1);
                    end
                end else if (r_slices != '0) begin
                    r_d      <= r_cur[WIDTH-1:0];
                    r_cur    <= r_cur >> WIDTH;
                    r_slices <= r_slices - c_SW'(1);
                end else if (!w_empty) begin
                    r_d      <= r_mem[r_rp][WIDTH-1:0];
                    r_cur    <= r_mem[r_rp] >> WIDTH;
                    r_slices <= c_SW'(c_RATIO - 1);
                end else begin
                    r_d         <= IDLE_WORD;
                    r_underflow <= 1'b1;
                end
            end

            // Flushing on WAIT_LOCK/TRAIN entry wins over anything loaded above
            if (w_flush) begin
                r_cur    <= '0;
                r_slices <= '0;
                r_wp     <= '0;
                r_rp     <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + c_AW'(1);
                if (w_pop)  r_rp <= r_rp + c_AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + c_LW'(1);
                    2'b01:   r_level <= r_level - c_LW'(1);
                    default: r_level <= r_level;
                endcase
            end

            if (w_enter_train) begin
                r_train_cnt <= '0;
                r_underflow <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_oserdes_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oserdes_word_feeder
//  Description : Scoreboard bench for oserdes_word_feeder; one instance with a
//                word every cycle and one with a word every fourth cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oserdes_word_feeder;
    localparam int MIN_TRAIN = 8;

    logic       clk;
    logic       rst_n;
    logic       en, pll_lock, train, din_valid, sel;
    logic [7:0] din;

    oserdes_word_feeder_if #(.WIDTH(4), .IN_WIDTH(8), .FIFO_DEPTH(4)) bus0 ();
    oserdes_word_feeder_if #(.WIDTH(4), .IN_WIDTH(8), .FIFO_DEPTH(4)) bus1 ();

    assign bus0.en = en & ~sel;   assign bus1.en = en & sel;
    assign bus0.pll_lock = pll_lock;   assign bus1.pll_lock = pll_lock;
    assign bus0.train = train;   assign bus1.train = train;
    assign bus0.din = din;   assign bus1.din = din;
    assign bus0.din_valid = din_valid & ~sel;   assign bus1.din_valid = din_valid & sel;

    oserdes_word_feeder #(.LOAD_INTERVAL(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    oserdes_word_feeder #(.LOAD_INTERVAL(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    wire [3:0] m_d         = sel ? bus1.d         : bus0.d;
    wire       m_load_word = sel ? bus1.load_word : bus0.load_word;
    wire       m_underflow = sel ? bus1.underflow : bus0.underflow;
    wire       m_din_ready = sel ? bus1.din_ready : bus0.din_ready;
    wire [2:0] m_level     = sel ? bus1.level     : bus0.level;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit         mon_on = 0;
    int         phase;          // 0 = training, 1 = running
    int         tcount;
    int         first_edge, last_edge, cyc = 0, lvl;
    bit         seen_first, t_edge;
    logic [3:0] last_d;
    logic [7:0] bq_data[$];
    int         bq_edge[$];
    logic [3:0] pend[$];
    logic [7:0] mb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cur_li();
        return sel ? 4 : 1;
    endfunction

    // Monitor: compares every output strobe and the FIFO status against the model
    always @(posedge clk) begin
        cyc    = cyc + 1;
        t_edge = train;
        #1;
        if (mon_on) begin
            if (m_load_word) begin
                if (!seen_first) chk("first_load_edge", 32'(cyc), 32'(first_edge));
                else             chk("load_period", 32'(cyc - last_edge), 32'(cur_li()));
                seen_first = 1;
                last_edge  = cyc;
                if (phase == 0) begin
                    chk("train_word", 32'(m_d), 32'h5);
                    chk("train_underflow_clear", 32'(m_underflow), 32'h0);
                    if (!t_edge && tcount >= MIN_TRAIN) phase = 1;
                    tcount++;
                end else begin
                    if (pend.size() == 0 && bq_data.size() > 0 && bq_edge[0] < cyc) begin
                        mb = bq_data.pop_front();
                        void'(bq_edge.pop_front());
                        for (int i = 0; i < 2; i++) pend.push_back(4'(mb >> (4 * i)));
                    end
                    if (pend.size() > 0) begin
                        chk("run_word", 32'(m_d), 32'(pend.pop_front()));
                    end else begin
                        chk("idle_word", 32'(m_d), 32'h0);
                        chk("underflow_flag", 32'(m_underflow), 32'(!t_edge));
                    end
                    if (t_edge) begin
                        phase = 0; tcount = 0;
                        bq_data.delete(); bq_edge.delete(); pend.delete();
                    end
                end
            end else if (seen_first) begin
                chk("d_hold", 32'(m_d), 32'(last_d));
            end
            last_d = m_d;
            if (phase == 1) begin
                lvl = 0;
                foreach (bq_edge[i]) if (bq_edge[i] <= cyc) lvl++;
                chk("level", 32'(m_level), 32'(lvl));
                chk("din_ready", 32'(m_din_ready), 32'(lvl < 4));
            end else begin
                chk("level_train", 32'(m_level), 32'h0);
                chk("din_ready_train", 32'(m_din_ready), 32'h0);
            end
        end
    end

    task automatic record(input logic [7:0] b);
        bq_data.push_back(b);
        bq_edge.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); din_valid = 1'b0; end
    endtask

    task automatic drive_cycles(input int n, input int vprob);
        repeat (n) begin
            @(negedge clk);
            din_valid = ($urandom_range(0, 99) < vprob);
            din       = 8'($urandom);
            if (din_valid && m_din_ready) record(din);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            din = b; din_valid = 1'b1;
            if (m_din_ready) begin record(b); ok = 1; end
        end
        chk("send_accepted", 32'(ok), 32'h1);
    endtask

    task automatic wait_run();
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            din_valid = 1'b0;
            if (phase == 1) ok = 1;
        end
        chk("reached_run", 32'(ok), 32'h1);
    endtask

    // Raise lock and enable on the selected instance; model restarts from training
    task automatic bringup();
        mon_on = 0;
        bq_data.delete(); bq_edge.delete(); pend.delete();
        @(negedge clk);
        din_valid  = 1'b0;
        pll_lock   = 1'b1;
        en         = 1'b1;
        first_edge = cyc + 3 + cur_li();
        seen_first = 0;
        phase      = 0;
        tcount     = 0;
        mon_on     = 1;
        wait_run();
    endtask

    initial begin
        bit seen_full, found;
        int cnt;
        rst_n = 1'b0; en = 1'b0; pll_lock = 1'b0; train = 1'b0;
        din = '0; din_valid = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d0", 32'(bus0.d), 0);           chk("rst_d1", 32'(bus1.d), 0);
        chk("rst_load0", 32'(bus0.load_word), 0); chk("rst_load1", 32'(bus1.load_word), 0);
        chk("rst_ready0", 32'(bus0.din_ready), 0); chk("rst_ready1", 32'(bus1.din_ready), 0);
        chk("rst_uf0", 32'(bus0.underflow), 0);  chk("rst_uf1", 32'(bus1.underflow), 0);
        chk("rst_level0", 32'(bus0.level), 0);   chk("rst_level1", 32'(bus1.level), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_load_without_lock", 32'(m_load_word), 0);

        // word-per-cycle instance
        bringup();
        send(8'hA5); send(8'h3C); idle(12);
        chk("underflow_sticky", 32'(m_underflow), 1);
        chk("idle_word_held", 32'(m_d), 0);
        drive_cycles(150, 50);

        // retrain request from RUN
        @(negedge clk); din_valid = 1'b0; train = 1'b1;
        idle(20);
        train = 1'b0;
        wait_run();
        drive_cycles(100, 40);

        // lose lock after the first nibble of 0xF1
        idle(12);
        send(8'hF1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk); din_valid = 1'b0;
            if (pend.size() == 1) found = 1;
        end
        chk("f1_first_nibble", 32'(found), 1);
        pll_lock = 1'b0; mon_on = 0;
        idle(3);
        repeat (5) begin @(negedge clk); chk("waitlock_no_load", 32'(m_load_word), 0); end
        chk("waitlock_level", 32'(m_level), 0);
        chk("waitlock_ready", 32'(m_din_ready), 0);
        bringup();
        drive_cycles(100, 60);

        // asynchronous reset in the middle of RUN
        @(negedge clk); din_valid = 1'b0;
        #2 rst_n = 1'b0; mon_on = 0;
        #1;
        chk("async_d", 32'(m_d), 0);
        chk("async_load", 32'(m_load_word), 0);
        chk("async_ready", 32'(m_din_ready), 0);
        chk("async_uf", 32'(m_underflow), 0);
        chk("async_level", 32'(m_level), 0);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        bringup();
        drive_cycles(80, 50);

        // word-every-fourth-cycle instance
        @(negedge clk); pll_lock = 1'b0; mon_on = 0; din_valid = 1'b0;
        idle(5);
        sel = 1'b1;
        bringup();
        drive_cycles(150, 60);
        seen_full = 0; cnt = 0;
        for (int k = 0; k < 600 && cnt < 32; k++) begin
            @(negedge clk);
            if (m_level == 3'd4 && !m_din_ready) seen_full = 1;
            din_valid = 1'b1; din = 8'($urandom);
            if (m_din_ready) begin record(din); cnt++; end
        end
        chk("fill_bytes_sent", 32'(cnt), 32);
        chk("fifo_reached_full", 32'(seen_full), 1);
        idle(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/oserdes_word_feeder.md
# oserdes_word_feeder

Fabric-side transmit feeder placed directly upstream of a 4-to-1 O_SERDES channel. It accepts a byte stream over a valid/ready handshake and buffers it in a small FIFO. Each byte is split into WIDTH-bit words, LSB-first, and the block drives the serializer's D bus and LOAD_WORD strobe at a fixed word cadence. It also handles PLL-lock gating, a link-training pattern, and underflow fill, so the serializer never sees undefined data.

## Interface
- WIDTH, 4: serializer word width; IN_WIDTH must be an integer multiple of it.
- IN_WIDTH, 8: input byte width; RATIO = IN_WIDTH/WIDTH words per byte.
- FIFO_DEPTH, 4: input FIFO entries, power of two, minimum 2.
- LOAD_INTERVAL, 1: CLK cycles between load events, range 1..16.
- MIN_TRAIN, 8: minimum TRAIN_WORD loads before RUN is allowed, minimum 1.
- TRAIN_WORD, 4'b0101: word sent during training.
- IDLE_WORD, 4'b0000: word sent on underflow.
- CLK, input, 1: fabric word clock, driven by the serializer clock output through CLK_BUF.
- RST_N, input, 1: asynchronous, active-low reset.
- EN, input, 1: block enable.
- PLL_LOCK, input, 1: PLL lock, asynchronous to CLK; the block synchronizes it with 2 flops.
- TRAIN, input, 1: request training pattern.
- DIN, input, IN_WIDTH: byte data.
- DIN_VALID, input, 1: byte valid.
- DIN_READY, output, 1: byte accepted when DIN_VALID && DIN_READY at a CLK edge.
- D, output, WIDTH: word to the serializer D port.
- LOAD_WORD, output, 1: word strobe to the serializer.
- UNDERFLOW, output, 1: sticky; set when IDLE_WORD is emitted in RUN.
- LEVEL, output, clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- States:
  - WAIT_LOCK: reset state.
  - TRAIN: training pattern.
  - RUN: data.
- Transitions:
  - Any state goes to WAIT_LOCK when lock_sync=0 or EN=0. This has priority over all other transitions.
  - WAIT_LOCK goes to TRAIN when lock_sync=1 and EN=1.
  - TRAIN goes to RUN at a load event when TRAIN=0 and train_cnt ≥ MIN_TRAIN.
  - RUN goes to TRAIN at a load event when TRAIN=1.
- Entering WAIT_LOCK or TRAIN flushes the FIFO and the partial-byte register.
  - Entering TRAIN also clears train_cnt and UNDERFLOW.
- Word timer:
  - Held at 0 in WAIT_LOCK.
  - Otherwise counts 0..LOAD_INTERVAL-1 and wraps.
  - A load event occurs in every cycle where timer = LOAD_INTERVAL-1.
- Behaviour at a load event, registered, evaluated in priority order:
  - TRAIN: D=TRAIN_WORD; train_cnt increments, saturating at MIN_TRAIN.
  - RUN with slices_left>0: D=cur[WIDTH-1:0]; cur shifts right by WIDTH; slices_left decrements.
  - RUN, otherwise, with FIFO non-empty: pop; D=popped[WIDTH-1:0]; cur=popped>>WIDTH; slices_left=RATIO-1.
  - RUN, otherwise, with FIFO empty: D=IDLE_WORD; UNDERFLOW=1.
- LOAD_WORD is 1 in the cycle after each load event and 0 otherwise. D holds its value between loads.
- DIN_READY = (state==RUN) && !full.
  - A push and a pop in the same cycle are both performed; LEVEL is unchanged.
  - A push is never accepted while full.
- In WAIT_LOCK, D holds its last value and LOAD_WORD=0.

## Timing
- Reset values: D=0, LOAD_WORD=0, DIN_READY=0, UNDERFLOW=0, LEVEL=0, state=WAIT_LOCK, timer=0.
- PLL_LOCK rise to state=TRAIN takes 3 CLK edges: 2 synchronizer flops plus the state register.
- First LOAD_WORD=1 occurs LOAD_INTERVAL cycles after state becomes TRAIN.
- With LOAD_INTERVAL=1, LOAD_WORD stays high continuously while not in WAIT_LOCK, and D changes every cycle.
- A byte pushed into an empty FIFO in RUN appears on D at the next load event at least 1 cycle later. There is no same-cycle bypass.
- Byte throughput is one byte per RATIO load events. DIN_READY drops only when LEVEL=FIFO_DEPTH.
- RST_N asserted mid-operation clears all state immediately. Outputs return to reset values asynchronously.
- EN or lock loss takes effect on the next CLK edge. Any load event in that same cycle is suppressed.

## Test plan
- Reset, then PLL_LOCK=1, EN=1, defaults:
  - state reaches TRAIN after 3 edges.
  - LOAD_WORD goes high one cycle later.
  - D=0101 for 8 loads.
- TRAIN=0 after training, push bytes 0xA5, 0x3C:
  - D sequence is 5, A, C, 3.
  - D then goes to 0 with UNDERFLOW=1.
- LOAD_INTERVAL=4:
  - LOAD_WORD is high 1 cycle in 4.
  - D is stable across the 3 intermediate cycles.
- Hold DIN_VALID=1 with the consumer slowed (LOAD_INTERVAL=4):
  - LEVEL reaches 4 and DIN_READY=0.
  - No bytes are lost or duplicated over 32 bytes.
  - Simultaneous push/pop keeps LEVEL constant.
- Drop PLL_LOCK mid-byte (after the first nibble of 0xF1):
  - WAIT_LOCK is reached; LOAD_WORD=0; FIFO is flushed.
  - After relock, TRAIN is re-entered with UNDERFLOW cleared.
- Assert RST_N=0 mid-RUN:
  - All outputs go to reset values without a CLK edge.
  - Resume is identical to a fresh start.
